// File: rtl/adc_multi_model_if.sv
// ---------------------------------------------------------------------------
// adc_multi_model_if
// Serial ADC bus between a multi-channel ADC reader (master) and the ADC
// model (slave).
//   run    : reader enables the model (0 = idle)
//   cs     : active-low chip select, high aborts / ends a frame
//   din    : serial channel address, MSB first
//   sd     : serial sample data from the ADC
//   done   : one-clock pulse after the last data bit
//   cur_ch : channel the next frame will sample
// ---------------------------------------------------------------------------
interface adc_multi_model_if #(
  parameter int ADDR_W = 2
);
  logic              run;
  logic              cs;
  logic              din;
  logic              sd;
  logic              done;
  logic [ADDR_W-1:0] cur_ch;

  modport master (output run, cs, din, input sd, done, cur_ch);
  modport slave  (input run, cs, din, output sd, done, cur_ch);
endinterface

// File: rtl/adc_multi_model.sv
// ---------------------------------------------------------------------------
// adc_multi_model
// Loopback model of a multi-channel serial SAR ADC with ADC128S022-style
// framing. Each channel carries an internally generated test waveform
// (square or ramp, offset per channel). A sample is held at frame start,
// shifted out MSB first after LEAD_ZEROS zero bits, and the channel for the
// next frame is captured serially from din. Everything runs on the falling
// edge of the shared serial clock.
// Ports:
//   clk_i   : serial clock, state updates on the falling edge
//   reset_i : synchronous active-high reset, sampled on the falling edge
//   bus     : slave side of adc_multi_model_if (run, cs, din, sd, done, cur_ch)
// ---------------------------------------------------------------------------
module adc_multi_model #(
  parameter int WIDTH      = 12,
  parameter int NUM_CH     = 4,
  parameter int FRAME_BITS = 16,
  parameter int LEAD_ZEROS = 1,
  parameter int ADDR_START = 2,
  parameter int PERIOD     = 10,
  parameter int MODE       = 0,
  parameter int HIGH       = 200,
  parameter int LOW        = 0,
  parameter int STEP       = 1,
  parameter int CH_OFFSET  = 256
) (
  input  logic              clk_i,
  input  logic              reset_i,
  adc_multi_model_if.slave  bus
);

  localparam int ADDR_W   = $clog2(NUM_CH);
  localparam int CNT_W    = $clog2(FRAME_BITS + 2);
  localparam int TMR_W    = $clog2(PERIOD + 2);
  localparam int IDX_W    = $clog2(WIDTH);
  localparam int DATA_TOP = WIDTH - 1 + LEAD_ZEROS;

  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LEAD_C     = CNT_W'(LEAD_ZEROS);
  localparam logic [CNT_W-1:0]  DATA_END_C = CNT_W'(LEAD_ZEROS + WIDTH);
  localparam logic [CNT_W-1:0]  ADDR_LO_C  = CNT_W'(ADDR_START);
  localparam logic [CNT_W-1:0]  ADDR_END_C = CNT_W'(ADDR_START + ADDR_W);
  localparam logic [CNT_W-1:0]  LAST_C     = CNT_W'(FRAME_BITS);
  localparam logic [TMR_W-1:0]  TMR_ZERO   = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0]  TMR_ONE    = TMR_W'(1);
  localparam logic [TMR_W-1:0]  PERIOD_C   = TMR_W'(PERIOD);
  localparam logic [WIDTH-1:0]  HIGH_C     = WIDTH'(HIGH);
  localparam logic [WIDTH-1:0]  LOW_C      = WIDTH'(LOW);
  localparam logic [WIDTH-1:0]  STEP_C     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0]  BASE_RST   = (MODE == 0) ? WIDTH'(HIGH) : {WIDTH{1'b0}};
  localparam logic [ADDR_W:0]   CH_LIMIT_C = (ADDR_W + 1)'(NUM_CH);

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [WIDTH-1:0]  base_q, base_d;
  logic [WIDTH-1:0]  held_q, held_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cur_ch_q, cur_ch_d;
  logic              sd_q, sd_d;
  logic              done_q, done_d;

  logic              tick_s;
  logic              in_data_s;
  logic              in_addr_s;
  logic              addr_full_s;
  logic              addr_ok_s;
  logic [IDX_W-1:0]  data_idx_s;

  // Channel level = shared waveform base plus a per-channel offset, mod 2^WIDTH.
  function automatic logic [WIDTH-1:0] ch_value(input logic [WIDTH-1:0] base,
                                                input logic [ADDR_W-1:0] ch);
    ch_value = base + WIDTH'(int'(ch) * CH_OFFSET);
  endfunction

  // Free-running waveform generator, independent of run and cs.
  always_comb begin
    tick_s  = (timer_q == PERIOD_C);
    timer_d = timer_q;
    base_d  = base_q;
    if (tick_s) begin
      timer_d = TMR_ZERO;
      if (MODE == 0) begin
        base_d = (base_q == HIGH_C) ? LOW_C : HIGH_C;
      end else begin
        base_d = base_q + STEP_C;
      end
    end else begin
      timer_d = timer_q + TMR_ONE;
      base_d  = base_q;
    end
  end

  // Frame sequencing: sample hold, serial data, done pulse, address capture/commit.
  always_comb begin
    in_data_s   = (bit_cnt_q >= LEAD_C) && (bit_cnt_q < DATA_END_C);
    in_addr_s   = (bit_cnt_q >= ADDR_LO_C) && (bit_cnt_q < ADDR_END_C);
    // bit_cnt_q still holds the frame position on the edge that ends the frame
    addr_full_s = (bit_cnt_q >= ADDR_END_C);
    addr_ok_s   = ({1'b0, addr_q} < CH_LIMIT_C);
    data_idx_s  = IDX_W'(DATA_TOP - int'(bit_cnt_q));

    bit_cnt_d = bit_cnt_q;
    held_d    = held_q;
    addr_d    = addr_q;
    cur_ch_d  = cur_ch_q;
    sd_d      = 1'b0;
    done_d    = 1'b0;

    if (!bus.run) begin
      bit_cnt_d = CNT_ZERO;
    end else if (bus.cs) begin
      bit_cnt_d = CNT_ZERO;
      if (addr_full_s && addr_ok_s) begin
        cur_ch_d = addr_q;
      end else begin
        cur_ch_d = cur_ch_q;
      end
    end else begin
      // held stays frozen for the rest of the frame regardless of ticks
      if (bit_cnt_q == CNT_ZERO) begin
        held_d = ch_value(base_q, cur_ch_q);
      end else begin
        held_d = held_q;
      end
      if (in_data_s) begin
        sd_d = held_q[data_idx_s];
      end else begin
        sd_d = 1'b0;
      end
      done_d = (bit_cnt_q == DATA_END_C);
      if (in_addr_s) begin
        addr_d = ADDR_W'({addr_q, bus.din});
      end else begin
        addr_d = addr_q;
      end
      // Saturated frame: commit the address without waiting for cs to rise
      if (bit_cnt_q == LAST_C) begin
        bit_cnt_d = LAST_C;
        if (addr_ok_s) begin
          cur_ch_d = addr_q;
        end else begin
          cur_ch_d = cur_ch_q;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_ONE;
        cur_ch_d  = cur_ch_q;
      end
    end
  end

  // State registers, updated on the falling edge of the serial clock.
  always_ff @(negedge clk_i) begin
    if (reset_i) begin
      bit_cnt_q <= CNT_ZERO;
      timer_q   <= TMR_ZERO;
      base_q    <= BASE_RST;
      held_q    <= {WIDTH{1'b0}};
      addr_q    <= {ADDR_W{1'b0}};
      cur_ch_q  <= {ADDR_W{1'b0}};
      sd_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      timer_q   <= timer_d;
      base_q    <= base_d;
      held_q    <= held_d;
      addr_q    <= addr_d;
      cur_ch_q  <= cur_ch_d;
      sd_q      <= sd_d;
      done_q    <= done_d;
    end
  end

  assign bus.sd     = sd_q;
  assign bus.done   = done_q;
  assign bus.cur_ch = cur_ch_q;

endmodule
